// File: rtl/ntt_pkg.sv
// Shared sizing constants and FSM encoding for the NTT result reader.
package ntt_pkg;

  localparam int N          = 256;
  localparam int DW         = 16;
  localparam int AW         = 8;
  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Small synchronous FIFO that absorbs returning RAM reads so the output stream can stall.
module rd_skid_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/ntt_result_reader.sv
// Streams NTT coefficients out of dual-port RAM as {odd, even} pairs after cal_done rises.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for a clean 0->1 edge on cal_done
//   ST_READ  | issuing pair reads k = 0..N/2-1 under credit
//   ST_DRAIN | all reads issued, emptying the skid FIFO
//   ST_FIN   | one-cycle done pulse
module ntt_result_reader #(
  parameter int N      = ntt_pkg::N,
  parameter int DW     = ntt_pkg::DW,
  parameter int AW     = ntt_pkg::AW,
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cal_done,
  output logic            rd_en,
  output logic [AW-1:0]   rd_addr_a,
  output logic [AW-1:0]   rd_addr_b,
  input  logic [DW-1:0]   rd_data_a,
  input  logic [DW-1:0]   rd_data_b,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [2*DW-1:0] m_data,
  output logic            m_last,
  output logic            busy,
  output logic            done
);

  import ntt_pkg::*;

  localparam int              KW     = AW - 1;
  localparam logic [KW-1:0]   K_LAST = KW'(N / 2 - 1);
  localparam int              FW     = 2 * DW + 1;
  localparam int              CW     = $clog2(FIFO_DEPTH + 1);

  state_t            state;
  state_t            state_nxt;
  logic              cal_q;
  logic              cal_rise;
  logic [KW-1:0]     k;
  logic              k_at_last;
  logic [RD_LAT-1:0] pipe_v;
  logic [RD_LAT-1:0] pipe_last;
  logic [1:0]        inflight;
  logic [3:0]        occupancy;
  logic              credit_ok;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [FW-1:0]     fifo_out;

  assign cal_rise  = cal_done && !cal_q;
  assign k_at_last = (k == K_LAST);
  assign rd_addr_a = {k, 1'b0};
  assign rd_addr_b = {k, 1'b1};

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + {1'b0, pipe_v[i]};
    end
  end

  // A beat leaving this cycle frees its slot, which keeps RD_LAT=3 at full rate.
  assign occupancy = 4'(fifo_count) + 4'(inflight) - 4'(pop);
  assign credit_ok = (occupancy < 4'(FIFO_DEPTH));

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_out[FW-1:1];
  assign m_last  = fifo_out[0];
  assign pop     = m_valid && m_ready;

  always_comb begin
    state_nxt = state;
    rd_en     = 1'b0;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cal_rise) state_nxt = ST_READ;
      end
      ST_READ: begin
        rd_en = credit_ok;
        if (credit_ok && k_at_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && m_last) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // cal_done history resets high so a level already present at release is not an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cal_q     <= 1'b1;
      k         <= '0;
      pipe_v    <= '0;
      pipe_last <= '0;
    end else begin
      state <= state_nxt;
      cal_q <= cal_done;
      if (rd_en) k <= k_at_last ? '0 : k + 1'b1;
      pipe_v[0]    <= rd_en;
      pipe_last[0] <= rd_en && k_at_last;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_last[i] <= pipe_last[i-1];
      end
    end
  end

  rd_skid_fifo #(
    .W     (FW),
    .DEPTH (FIFO_DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (pipe_v[RD_LAT-1]),
    .push_data ({rd_data_b, rd_data_a, pipe_last[RD_LAT-1]}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ntt_result_reader.sv
// Bench for ntt_result_reader: RD_LAT=1 and RD_LAT=3 instances share stimulus and are
// scored against an ordered beat list derived from the RAM image.
module tb_ntt_result_reader;

  localparam int N     = 256;
  localparam int DW    = 16;
  localparam int AW    = 8;
  localparam int HALF  = N / 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cal_done = 1'b0;
  logic m_ready = 1'b0;

  logic            rd_en_v [2];
  logic [AW-1:0]   ra_v    [2];
  logic [AW-1:0]   rb_v    [2];
  logic [DW-1:0]   da_v    [2];
  logic [DW-1:0]   db_v    [2];
  logic            mv_v    [2];
  logic [2*DW-1:0] md_v    [2];
  logic            ml_v    [2];
  logic            busy_v  [2];
  logic            done_v  [2];

  logic [DW-1:0] mem [N];
  logic [DW-1:0] lat1_a, lat1_b;
  logic [DW-1:0] lat3_a [3];
  logic [DW-1:0] lat3_b [3];

  always #5 clk = ~clk;

  // RAM models: data appears exactly RD_LAT cycles after the read strobe, X otherwise
  always @(posedge clk) begin
    lat1_a    <= rd_en_v[0] ? mem[ra_v[0]] : 'x;
    lat1_b    <= rd_en_v[0] ? mem[rb_v[0]] : 'x;
    lat3_a[0] <= rd_en_v[1] ? mem[ra_v[1]] : 'x;
    lat3_b[0] <= rd_en_v[1] ? mem[rb_v[1]] : 'x;
    lat3_a[1] <= lat3_a[0];
    lat3_b[1] <= lat3_b[0];
    lat3_a[2] <= lat3_a[1];
    lat3_b[2] <= lat3_b[1];
  end
  assign da_v[0] = lat1_a;
  assign db_v[0] = lat1_b;
  assign da_v[1] = lat3_a[2];
  assign db_v[1] = lat3_b[2];

  ntt_result_reader #(.N(N), .DW(DW), .AW(AW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .cal_done(cal_done),
    .rd_en(rd_en_v[0]), .rd_addr_a(ra_v[0]), .rd_addr_b(rb_v[0]),
    .rd_data_a(da_v[0]), .rd_data_b(db_v[0]),
    .m_valid(mv_v[0]), .m_ready(m_ready), .m_data(md_v[0]), .m_last(ml_v[0]),
    .busy(busy_v[0]), .done(done_v[0])
  );

  ntt_result_reader #(.N(N), .DW(DW), .AW(AW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .cal_done(cal_done),
    .rd_en(rd_en_v[1]), .rd_addr_a(ra_v[1]), .rd_addr_b(rb_v[1]),
    .rd_data_a(da_v[1]), .rd_data_b(db_v[1]),
    .m_valid(mv_v[1]), .m_ready(m_ready), .m_data(md_v[1]), .m_last(ml_v[1]),
    .busy(busy_v[1]), .done(done_v[1])
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int t_start = 0;
  int iss [2];
  int acc [2];
  int first_rd [2];
  int first_mv [2];
  int last_cyc [2];
  int done_cnt [2];
  bit stall [2];
  bit fin_due [2];
  logic [2*DW:0] hold [2];

  task automatic clear_model();
    for (int d = 0; d < 2; d++) begin
      iss[d] = 0; acc[d] = 0; first_rd[d] = -1; first_mv[d] = -1;
      last_cyc[d] = -1; done_cnt[d] = 0; stall[d] = 0; fin_due[d] = 0; hold[d] = '0;
    end
  endtask

  // One clock: drive m_ready at the falling edge, then score both instances.
  task automatic step(input bit rdy);
    logic [2*DW-1:0] exp_data;
    bit acc_now;
    @(negedge clk);
    m_ready = rdy;
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      acc_now = mv_v[d] && rdy;
      checks++;
      if (done_v[d] !== fin_due[d]) begin
        errors++;
        $display("FAIL done_pulse dut%0d cyc=%0d got=%b want=%b", d, cyc, done_v[d], fin_due[d]);
      end
      if (done_v[d] === 1'b1) done_cnt[d]++;
      fin_due[d] = 0;
      if (rd_en_v[d] === 1'b1) begin
        if (first_rd[d] < 0) first_rd[d] = cyc - t_start;
        checks++;
        if (iss[d] >= HALF) begin
          errors++;
          $display("FAIL extra_read dut%0d got=%0d reads want<=%0d", d, iss[d] + 1, HALF);
        end else if (ra_v[d] !== AW'(2 * iss[d]) || rb_v[d] !== AW'(2 * iss[d] + 1)) begin
          errors++;
          $display("FAIL rd_addr dut%0d got=%0d/%0d want=%0d/%0d", d, ra_v[d], rb_v[d],
                   2 * iss[d], 2 * iss[d] + 1);
        end
        checks++;
        if (iss[d] - acc[d] + 1 - (acc_now ? 1 : 0) > DEPTH) begin
          errors++;
          $display("FAIL credit dut%0d got=%0d outstanding want<=%0d", d,
                   iss[d] - acc[d] + 1 - (acc_now ? 1 : 0), DEPTH);
        end
        iss[d]++;
      end
      if (stall[d]) begin
        checks++;
        if (mv_v[d] !== 1'b1 || {ml_v[d], md_v[d]} !== hold[d]) begin
          errors++;
          $display("FAIL stall_stable dut%0d got=%b/%h want=1/%h", d, mv_v[d],
                   {ml_v[d], md_v[d]}, hold[d]);
        end
      end
      if (acc_now) begin
        if (first_mv[d] < 0) first_mv[d] = cyc - t_start;
        checks++;
        if (acc[d] >= HALF) begin
          errors++;
          $display("FAIL extra_beat dut%0d got=%0d beats want=%0d", d, acc[d] + 1, HALF);
        end else begin
          exp_data = {mem[2 * acc[d] + 1], mem[2 * acc[d]]};
          if (md_v[d] !== exp_data || ml_v[d] !== (acc[d] == HALF - 1)) begin
            errors++;
            $display("FAIL beat dut%0d k=%0d got=%h/%b want=%h/%b", d, acc[d], md_v[d],
                     ml_v[d], exp_data, (acc[d] == HALF - 1));
          end
          if (acc[d] == HALF - 1) begin
            fin_due[d] = 1;
            last_cyc[d] = cyc - t_start;
          end
        end
        acc[d]++;
      end
      stall[d] = mv_v[d] && !rdy;
      hold[d]  = {ml_v[d], md_v[d]};
    end
  endtask

  task automatic run_to_done(input int budget, input bit rand_ready);
    int n = 0;
    while (!(acc[0] >= HALF && acc[1] >= HALF && !busy_v[0] && !busy_v[1]) && n < budget) begin
      step(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout got=%0d/%0d beats want=%0d", acc[0], acc[1], HALF);
    end
  endtask

  task automatic check_complete(input string tag);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (acc[d] != HALF || iss[d] != HALF || done_cnt[d] != 1) begin
        errors++;
        $display("FAIL %s_complete dut%0d got=beats %0d reads %0d dones %0d want=%0d/%0d/1",
                 tag, d, acc[d], iss[d], done_cnt[d], HALF, HALF);
      end
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) mem[i] = DW'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cal_done = 1'b1;
    clear_model();
    repeat (3) step(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({rd_en_v[d], ra_v[d], rb_v[d], mv_v[d], ml_v[d], busy_v[d], done_v[d]}
          !== {1'b0, 8'd0, 8'd1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_ctrl dut%0d got=%b %0d %0d %b %b %b %b want=0 0 1 0 0 0 0", d,
                 rd_en_v[d], ra_v[d], rb_v[d], mv_v[d], ml_v[d], busy_v[d], done_v[d]);
      end
      checks++;
      if (md_v[d] !== '0) begin
        errors++;
        $display("FAIL reset_data dut%0d got=%h want=0", d, md_v[d]);
      end
    end
    rst = 1'b0;
    repeat (8) step(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || iss[d] != 0) begin
        errors++;
        $display("FAIL held_cal_no_trigger dut%0d got=busy %b reads %0d want=0/0", d,
                 busy_v[d], iss[d]);
      end
    end
    cal_done = 1'b0;
    step(1'b1);
  endtask

  task automatic test_basic();
    for (int i = 0; i < N; i++) mem[i] = DW'(i);
    clear_model();
    cal_done = 1'b1;
    t_start = cyc;
    run_to_done(400, 1'b0);
    check_complete("basic");
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (first_rd[d] != 1 || first_mv[d] != 2 + (d == 0 ? 1 : 3)) begin
        errors++;
        $display("FAIL latency dut%0d got=rd %0d mv %0d want=rd 1 mv %0d", d, first_rd[d],
                 first_mv[d], 2 + (d == 0 ? 1 : 3));
      end
      checks++;
      if (last_cyc[d] - first_mv[d] != HALF - 1) begin
        errors++;
        $display("FAIL throughput dut%0d got=%0d cycles want=%0d", d,
                 last_cyc[d] - first_mv[d], HALF - 1);
      end
    end
    repeat (10) step(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0 || iss[d] != HALF) begin
        errors++;
        $display("FAIL level_no_retrigger dut%0d got=busy %b reads %0d want=0/%0d", d,
                 busy_v[d], iss[d], HALF);
      end
    end
    cal_done = 1'b0;
    step(1'b1);
  endtask

  task automatic test_random_ready();
    fill_random();
    clear_model();
    cal_done = 1'b1;
    t_start = cyc;
    run_to_done(3000, 1'b1);
    check_complete("random_ready");
    cal_done = 1'b0;
    step(1'b1);
  endtask

  task automatic test_stall();
    fill_random();
    clear_model();
    cal_done = 1'b1;
    t_start = cyc;
    repeat (20) step(1'b0);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (iss[d] != DEPTH || mv_v[d] !== 1'b1) begin
        errors++;
        $display("FAIL stall_reads dut%0d got=%0d reads valid %b want=%0d reads valid 1", d,
                 iss[d], mv_v[d], DEPTH);
      end
    end
    run_to_done(600, 1'b0);
    check_complete("stall");
    cal_done = 1'b0;
    step(1'b1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    fill_random();
    clear_model();
    cal_done = 1'b1;
    t_start = cyc;
    while (acc[0] < 60 && n < 1000) begin
      step(1'($urandom_range(0, 1)));
      n++;
    end
    checks++;
    if (acc[0] < 60) begin
      errors++;
      $display("FAIL reach_beat60 got=%0d want=60", acc[0]);
    end
    rst = 1'b1;
    clear_model();
    step(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (mv_v[d] !== 1'b0 || busy_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset dut%0d got=valid %b busy %b want=0/0", d, mv_v[d], busy_v[d]);
      end
    end
    rst = 1'b0;
    repeat (4) step(1'b1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (iss[d] != 0 || acc[d] != 0) begin
        errors++;
        $display("FAIL post_reset_quiet dut%0d got=reads %0d beats %0d want=0/0", d,
                 iss[d], acc[d]);
      end
    end
    cal_done = 1'b0;
    step(1'b1);
    fill_random();
    cal_done = 1'b1;
    t_start = cyc;
    run_to_done(3000, 1'b1);
    check_complete("restart");
    cal_done = 1'b0;
    step(1'b1);
  endtask

  task automatic test_retrigger();
    fill_random();
    clear_model();
    cal_done = 1'b1;
    t_start = cyc;
    repeat (30) step(1'b1);
    cal_done = 1'b0;
    step(1'b1);
    cal_done = 1'b1;
    step(1'b1);
    run_to_done(400, 1'b0);
    repeat (20) step(1'b1);
    check_complete("retrigger");
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (busy_v[d] !== 1'b0) begin
        errors++;
        $display("FAIL retrigger_idle dut%0d got=busy %b want=0", d, busy_v[d]);
      end
    end
    cal_done = 1'b0;
    step(1'b1);
  endtask

  initial begin
    clear_model();
    test_reset();
    test_basic();
    test_random_ready();
    test_stall();
    test_reset_mid();
    test_retrigger();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
